// File: rtl/pixel_readout_sched.sv
// Column readout scheduler: one load strobe per event, then round-robin service of
// every pixel flagging unreadHit, forwarding each pixel word over valid/ready.
module pixel_readout_sched #(
    parameter int NPIX    = 16,
    parameter int DW      = 36,
    parameter int MAXHITS = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               evtStart,
    input  logic [NPIX-1:0]    unreadHit,
    input  logic [NPIX*DW-1:0] pixDout,
    input  logic               outReady,
    output logic               load,
    output logic [NPIX-1:0]    read,
    output logic [DW-1:0]      outData,
    output logic [3:0]         outPixID,
    output logic               outValid,
    output logic               evtDone,
    output logic               evtTrunc,
    output logic               busy
);

    localparam int CW = $clog2(MAXHITS + 1);

    typedef enum logic [2:0] {IDLE, LOAD, SETTLE, SCAN, SEND, GAP, DONE} stateT;

    stateT          state;
    logic [3:0]     rrPtr;
    logic [CW-1:0]  hitCnt;
    logic [3:0]     grantIdx;
    logic           anyHit;

    function automatic logic [3:0] wrapIdx(input logic [3:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NPIX) s -= NPIX;
        return 4'(s);
    endfunction

    // Walk downwards so the nearest set bit at or after rrPtr is the last one written.
    // NOTE: every always_comb output gets a default first; a missed path would infer a latch.
    always_comb begin
        anyHit   = |unreadHit;
        grantIdx = '0;
        for (int k = NPIX - 1; k >= 0; k--) begin
            if (unreadHit[wrapIdx(rrPtr, k)]) grantIdx = wrapIdx(rrPtr, k);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            rrPtr    <= '0;
            hitCnt   <= '0;
            load     <= 1'b0;
            read     <= '0;
            outData  <= '0;
            outPixID <= '0;
            outValid <= 1'b0;
            evtDone  <= 1'b0;
            evtTrunc <= 1'b0;
            busy     <= 1'b0;
        end else begin
            load     <= 1'b0;
            read     <= '0;
            evtDone  <= 1'b0;
            evtTrunc <= 1'b0;
            case (state)
                IDLE: begin
                    if (evtStart) begin
                        state  <= LOAD;
                        hitCnt <= '0;
                        busy   <= 1'b1;
                    end
                end
                LOAD: begin
                    load  <= 1'b1;
                    state <= SETTLE;
                end
                SETTLE: state <= SCAN;
                SCAN: begin
                    if (!anyHit) begin
                        state   <= DONE;
                        evtDone <= 1'b1;
                    end else if (hitCnt == CW'(MAXHITS)) begin
                        state    <= DONE;
                        evtDone  <= 1'b1;
                        evtTrunc <= 1'b1;
                    end else begin
                        outData  <= pixDout[int'(grantIdx)*DW +: DW];
                        outPixID <= grantIdx;
                        outValid <= 1'b1;
                        read     <= NPIX'(1) << grantIdx;
                        rrPtr    <= (grantIdx == 4'(NPIX - 1)) ? 4'd0 : grantIdx + 4'd1;
                        if (hitCnt != CW'(MAXHITS)) hitCnt <= hitCnt + 1'b1;
                        state    <= SEND;
                    end
                end
                SEND: begin
                    if (outReady) begin
                        outValid <= 1'b0;
                        state    <= GAP;
                    end
                end
                // Gives the granted pixel one cycle to drop its unreadHit before rescanning.
                GAP: state <= SCAN;
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_readout_sched.sv
// Self-checking bench for pixel_readout_sched: behavioural pixel buffers plus a
// scoreboard of expected (pixel id, word) pairs popped on every read strobe.
module tb_pixel_readout_sched;

    localparam int NPIX = 16;
    localparam int DW   = 36;

    typedef struct {
        logic [3:0]    id;
        logic [DW-1:0] data;
    } wordT;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               outReady = 1'b1;
    logic               evtStart = 1'b0, evtStart2 = 1'b0;
    logic [NPIX-1:0]    unreadHit = '0, unreadHit2 = '0;
    logic [NPIX-1:0]    mask1 = '0, mask2 = '0;
    logic [NPIX*DW-1:0] pixDout;

    logic            load, outValid, evtDone, evtTrunc, busy;
    logic [NPIX-1:0] read;
    logic [DW-1:0]   outData;
    logic [3:0]      outPixID;
    logic            load2, outValid2, evtDone2, evtTrunc2, busy2;
    logic [NPIX-1:0] read2;
    logic [DW-1:0]   outData2;
    logic [3:0]      outPixID2;

    int   errors = 0;
    int   checks = 0;
    int   loadCnt = 0;
    int   readCnt = 0;
    int   readCnt2 = 0;
    wordT sb1[$];
    wordT sb2[$];

    always #5 clk = ~clk;

    pixel_readout_sched #(.NPIX(NPIX), .DW(DW), .MAXHITS(16)) dut (
        .clk(clk), .reset(reset), .evtStart(evtStart), .unreadHit(unreadHit),
        .pixDout(pixDout), .outReady(outReady), .load(load), .read(read),
        .outData(outData), .outPixID(outPixID), .outValid(outValid),
        .evtDone(evtDone), .evtTrunc(evtTrunc), .busy(busy)
    );

    pixel_readout_sched #(.NPIX(NPIX), .DW(DW), .MAXHITS(2)) dut2 (
        .clk(clk), .reset(reset), .evtStart(evtStart2), .unreadHit(unreadHit2),
        .pixDout(pixDout), .outReady(outReady), .load(load2), .read(read2),
        .outData(outData2), .outPixID(outPixID2), .outValid(outValid2),
        .evtDone(evtDone2), .evtTrunc(evtTrunc2), .busy(busy2)
    );

    // Pixel buffers: a load latches the event's hit mask, a read clears that pixel's flag.
    always @(posedge clk) begin
        if (load) unreadHit <= mask1;
        else      unreadHit <= unreadHit & ~read;
        if (load2) unreadHit2 <= mask2;
        else       unreadHit2 <= unreadHit2 & ~read2;
    end

    always @(negedge clk) begin
        wordT e;
        logic [NPIX-1:0] expRead;
        if (load) loadCnt++;
        if (read !== '0) begin
            readCnt++;
            checks++;
            if (sb1.size() == 0) begin
                errors++;
                $display("FAIL word1_unexpected: read=%h id=%0d data=%h, no word expected", read, outPixID, outData);
            end else begin
                e = sb1.pop_front();
                expRead = 16'(1) << e.id;
                if (read !== expRead || outPixID !== e.id || outData !== e.data || outValid !== 1'b1) begin
                    errors++;
                    $display("FAIL word1: got id=%0d data=%h read=%h valid=%b, want id=%0d data=%h read=%h valid=1",
                             outPixID, outData, read, outValid, e.id, e.data, expRead);
                end
            end
        end
    end

    always @(negedge clk) begin
        wordT e;
        logic [NPIX-1:0] expRead;
        if (read2 !== '0) begin
            readCnt2++;
            checks++;
            if (sb2.size() == 0) begin
                errors++;
                $display("FAIL word2_unexpected: read=%h id=%0d data=%h, no word expected", read2, outPixID2, outData2);
            end else begin
                e = sb2.pop_front();
                expRead = 16'(1) << e.id;
                if (read2 !== expRead || outPixID2 !== e.id || outData2 !== e.data || outValid2 !== 1'b1) begin
                    errors++;
                    $display("FAIL word2: got id=%0d data=%h read=%h valid=%b, want id=%0d data=%h read=%h valid=1",
                             outPixID2, outData2, read2, outValid2, e.id, e.data, expRead);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic waitDone(input bit onDut2, output int cyc, output bit seen);
        seen = 1'b0;
        cyc  = 0;
        for (int k = 1; k <= 300; k++) begin
            @(negedge clk);
            if ((onDut2 ? evtDone2 : evtDone) === 1'b1) begin
                seen = 1'b1;
                cyc  = k;
                break;
            end
        end
    endtask

    task automatic waitValid(input string name);
        bit seen;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (outValid === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_valid_timeout: outValid=%b, want 1 within 20 cycles", name, outValid);
        end
    endtask

    // Runs one event with outReady=1; idList holds the expected grant order, 4 bits per word.
    task automatic runEvent(input string name, input logic [15:0] mask, input int nWords,
                            input logic [15:0] idList, input logic expTrunc, input bit onDut2);
        wordT w;
        int   cyc, r0;
        bit   seen;
        logic trunc;
        r0 = onDut2 ? readCnt2 : readCnt;
        for (int j = 0; j < nWords; j++) begin
            w.id   = idList[j*4 +: 4];
            w.data = DW'(36'hA0) + DW'(w.id);
            if (onDut2) sb2.push_back(w);
            else        sb1.push_back(w);
        end
        if (onDut2) begin mask2 = mask; evtStart2 = 1'b1; end
        else        begin mask1 = mask; evtStart  = 1'b1; end
        @(negedge clk);
        evtStart  = 1'b0;
        evtStart2 = 1'b0;
        waitDone(onDut2, cyc, seen);
        trunc = onDut2 ? evtTrunc2 : evtTrunc;
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s_done_timeout: evtDone never rose within 300 cycles", name);
        end
        checks++;
        if (cyc !== 3 * nWords + 3) begin
            errors++;
            $display("FAIL %s_done_latency: got %0d cycles, want %0d", name, cyc, 3 * nWords + 3);
        end
        checks++;
        if (trunc !== expTrunc) begin
            errors++;
            $display("FAIL %s_trunc: got %b, want %b", name, trunc, expTrunc);
        end
        checks++;
        if ((onDut2 ? readCnt2 : readCnt) - r0 !== nWords) begin
            errors++;
            $display("FAIL %s_read_count: got %0d, want %0d", name, (onDut2 ? readCnt2 : readCnt) - r0, nWords);
        end
        checks++;
        if ((onDut2 ? sb2.size() : sb1.size()) !== 0) begin
            errors++;
            $display("FAIL %s_words_missing: got %0d left, want 0", name, onDut2 ? sb2.size() : sb1.size());
        end
        @(negedge clk);
        checks++;
        if ((onDut2 ? {evtDone2, busy2} : {evtDone, busy}) !== 2'b00) begin
            errors++;
            $display("FAIL %s_idle_after: got evtDone,busy=%b, want 00",
                     name, onDut2 ? {evtDone2, busy2} : {evtDone, busy});
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({load, read, outData, outPixID, outValid, evtDone, evtTrunc, busy} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got load=%b read=%h data=%h id=%0d valid=%b done=%b trunc=%b busy=%b, want all 0",
                     load, read, outData, outPixID, outValid, evtDone, evtTrunc, busy);
        end
        checks++;
        if ({load2, read2, outData2, outPixID2, outValid2, evtDone2, evtTrunc2, busy2} !== '0) begin
            errors++;
            $display("FAIL reset_outputs2: got load=%b read=%h valid=%b done=%b busy=%b, want all 0",
                     load2, read2, outValid2, evtDone2, busy2);
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({load, read, outValid, evtDone, busy} !== '0) begin
            errors++;
            $display("FAIL reset_release_idle: got load=%b read=%h valid=%b done=%b busy=%b, want all 0",
                     load, read, outValid, evtDone, busy);
        end
    endtask

    task automatic test_empty_event();
        logic [3:0] loadSeq, doneSeq;
        int         r0;
        r0    = readCnt;
        mask1 = '0;
        evtStart = 1'b1;
        @(negedge clk);
        evtStart = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL empty_busy: got %b, want 1", busy);
        end
        loadSeq[0] = load;
        doneSeq[0] = evtDone;
        for (int k = 1; k < 4; k++) begin
            @(negedge clk);
            loadSeq[k] = load;
            doneSeq[k] = evtDone;
        end
        checks++;
        if (loadSeq !== 4'b0010) begin
            errors++;
            $display("FAIL empty_load_timing: got %b, want 0010", loadSeq);
        end
        checks++;
        if (doneSeq !== 4'b1000) begin
            errors++;
            $display("FAIL empty_done_timing: got %b, want 1000", doneSeq);
        end
        checks++;
        if (evtTrunc !== 1'b0 || readCnt !== r0) begin
            errors++;
            $display("FAIL empty_trunc_reads: got trunc=%b reads=%0d, want trunc=0 reads=0", evtTrunc, readCnt - r0);
        end
        @(negedge clk);
        checks++;
        if ({evtDone, busy} !== 2'b00) begin
            errors++;
            $display("FAIL empty_idle_after: got evtDone,busy=%b, want 00", {evtDone, busy});
        end
    endtask

    task automatic test_round_robin();
        runEvent("rr_wrap_a", 16'h0005, 2, 16'h0020, 1'b0, 1'b0);
        runEvent("rr_mid",    16'h0018, 2, 16'h0043, 1'b0, 1'b0);
        runEvent("rr_wrap_b", 16'h0021, 2, 16'h0005, 1'b0, 1'b0);
    endtask

    task automatic test_stall();
        wordT       w;
        logic [DW-1:0] holdData;
        int         l0, cyc;
        bit         seen;
        l0 = loadCnt;
        w.id = 4'd1; w.data = 36'hA1; sb1.push_back(w);
        w.id = 4'd2; w.data = 36'hA2; sb1.push_back(w);
        mask1    = 16'h0006;
        outReady = 1'b0;
        evtStart = 1'b1;
        @(negedge clk);
        evtStart = 1'b0;
        waitValid("stall");
        holdData = 36'hA1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            evtStart = (k == 4);
            checks++;
            if (outValid !== 1'b1 || outData !== holdData || outPixID !== 4'd1 || read !== '0 || evtDone !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got valid=%b data=%h id=%0d read=%h done=%b, want valid=1 data=%h id=1 read=0 done=0",
                         k, outValid, outData, outPixID, read, evtDone, holdData);
            end
        end
        evtStart = 1'b0;
        outReady = 1'b1;
        waitDone(1'b0, cyc, seen);
        checks++;
        if (!seen || sb1.size() !== 0) begin
            errors++;
            $display("FAIL stall_finish: got done=%b words_left=%0d, want done=1 words_left=0", seen, sb1.size());
        end
        repeat (5) @(negedge clk);
        checks++;
        if (loadCnt - l0 !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stall_ignored_start: got loads=%0d busy=%b, want loads=1 busy=0", loadCnt - l0, busy);
        end
    endtask

    task automatic test_truncate();
        runEvent("trunc_over",  16'h000F, 2, 16'h0010, 1'b1, 1'b1);
        runEvent("trunc_exact", 16'h0003, 2, 16'h0010, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid_event();
        wordT w;
        int   l0, r0;
        w.id = 4'd4; w.data = 36'hA4; sb1.push_back(w);
        mask1    = 16'h0030;
        outReady = 1'b0;
        evtStart = 1'b1;
        @(negedge clk);
        evtStart = 1'b0;
        waitValid("midrst");
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({load, read, outData, outPixID, outValid, evtDone, evtTrunc, busy} !== '0) begin
            errors++;
            $display("FAIL midrst_async: got valid=%b data=%h id=%0d busy=%b read=%h, want all 0",
                     outValid, outData, outPixID, busy, read);
        end
        @(negedge clk);
        checks++;
        if ({load, read, outData, outPixID, outValid, evtDone, evtTrunc, busy} !== '0) begin
            errors++;
            $display("FAIL midrst_held: got valid=%b data=%h id=%0d busy=%b, want all 0", outValid, outData, outPixID, busy);
        end
        reset    = 1'b1;
        outReady = 1'b1;
        l0 = loadCnt;
        r0 = readCnt;
        repeat (4) @(negedge clk);
        checks++;
        if (loadCnt !== l0 || readCnt !== r0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got loads=%0d reads=%0d busy=%b, want 0 0 0", loadCnt - l0, readCnt - r0, busy);
        end
        runEvent("midrst_restart", 16'h0042, 2, 16'h0061, 1'b0, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < NPIX; i++) pixDout[i*DW +: DW] = DW'(36'hA0) + DW'(i);
        repeat (3) @(negedge clk);
        test_reset();
        test_empty_event();
        runEvent("two_hits", 16'h0005, 2, 16'h0020, 1'b0, 1'b0);
        test_round_robin();
        test_stall();
        test_truncate();
        test_reset_mid_event();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
